// File: rtl/dsp_operand_fanout.sv
// Operand sequencer: frames a serial A,B,C stream and fans each triple out to three AXI streams.
// Optional build macro DSP_OPERAND_OVERLAP_EN overlaps collection of the next triple with presentation.
module dsp_operand_fanout #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_tdata,
    input  logic             input_tvalid,
    output logic             input_tready,
    input  logic             input_tlast,
    output logic [WIDTH-1:0] output_a_tdata,
    output logic             output_a_tvalid,
    input  logic             output_a_tready,
    output logic [WIDTH-1:0] output_b_tdata,
    output logic             output_b_tvalid,
    input  logic             output_b_tready,
    output logic [WIDTH-1:0] output_c_tdata,
    output logic             output_c_tvalid,
    input  logic             output_c_tready,
    output logic             frame_error
);

    typedef enum logic [1:0] {
        COLLECT_A,
        COLLECT_B,
        COLLECT_C,
        DROP
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_hold, b_hold;
    logic             loaded, done_a, done_b, done_c;
    logic             hs_a, hs_b, hs_c, retire, accept, load, err_next;

    assign output_a_tvalid = loaded & ~done_a;
    assign output_b_tvalid = loaded & ~done_b;
    assign output_c_tvalid = loaded & ~done_c;

    assign hs_a   = output_a_tvalid & output_a_tready;
    assign hs_b   = output_b_tvalid & output_b_tready;
    assign hs_c   = output_c_tvalid & output_c_tready;
    assign retire = loaded & (done_a | hs_a) & (done_b | hs_b) & (done_c | hs_c);

`ifdef DSP_OPERAND_OVERLAP_EN
    // Only the completing C word must wait for the present stage to free up.
    assign input_tready = ~rst & ~((state == COLLECT_C) & loaded & ~retire);
`else
    assign input_tready = ~rst & ~loaded;
`endif

    assign accept = input_tvalid & input_tready;

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        load       = 1'b0;
        if (accept) begin
            case (state)
                COLLECT_A: begin
                    if (input_tlast) err_next = 1'b1;
                    else             state_next = COLLECT_B;
                end
                COLLECT_B: begin
                    if (input_tlast) begin
                        err_next   = 1'b1;
                        state_next = COLLECT_A;
                    end else begin
                        state_next = COLLECT_C;
                    end
                end
                COLLECT_C: begin
                    if (input_tlast) begin
                        load       = 1'b1;
                        state_next = COLLECT_A;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (input_tlast) state_next = COLLECT_A;
                end
                default: state_next = COLLECT_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT_A;
            frame_error <= 1'b0;
            a_hold      <= '0;
            b_hold      <= '0;
        end else begin
            state       <= state_next;
            frame_error <= err_next;
            if (accept && state == COLLECT_A) a_hold <= input_tdata;
            if (accept && state == COLLECT_B) b_hold <= input_tdata;
        end
    end

    // A load on the retiring edge takes priority so the next triple follows with no valid gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_a_tdata <= '0;
            output_b_tdata <= '0;
            output_c_tdata <= '0;
            loaded         <= 1'b0;
            done_a         <= 1'b0;
            done_b         <= 1'b0;
            done_c         <= 1'b0;
        end else if (load) begin
            output_a_tdata <= a_hold;
            output_b_tdata <= b_hold;
            output_c_tdata <= input_tdata;
            loaded         <= 1'b1;
            done_a         <= 1'b0;
            done_b         <= 1'b0;
            done_c         <= 1'b0;
        end else if (retire) begin
            loaded <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            done_c <= 1'b0;
        end else begin
            done_a <= done_a | hs_a;
            done_b <= done_b | hs_b;
            done_c <= done_c | hs_c;
        end
    end

endmodule

// File: tb/tb_dsp_operand_fanout.sv
// Self-checking bench for dsp_operand_fanout: directed framing/timing steps plus randomized frames vs a parsing model.
module tb_dsp_operand_fanout;
    localparam int W = 16;
`ifdef DSP_OPERAND_OVERLAP_EN
    localparam int EXP_PERIOD = 3;
`else
    localparam int EXP_PERIOD = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [W-1:0] da, db, dc;
    logic         va, vb, vc, fe;
    logic         a_rdy, b_rdy, c_rdy;
    logic         fix_a = 1'b1, fix_b = 1'b1, fix_c = 1'b1, rand_rdy = 1'b0;
    logic         rnd_a = 1'b1, rnd_b = 1'b1, rnd_c = 1'b1;

    int unsigned  cyc = 0, acc_cyc = 0;
    int           errors = 0, checks = 0, err_seen = 0;

    logic [W-1:0] got_a[$], got_b[$], got_c[$];
    logic [W-1:0] exp_a[$], exp_b[$], exp_c[$];
    logic [W-1:0] m_cur[$];
    bit           m_drop = 0;
    int           exp_err = 0;

    assign a_rdy = rand_rdy ? rnd_a : fix_a;
    assign b_rdy = rand_rdy ? rnd_b : fix_b;
    assign c_rdy = rand_rdy ? rnd_c : fix_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_operand_fanout #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .input_tdata(in_data), .input_tvalid(in_valid), .input_tready(in_ready), .input_tlast(in_last),
        .output_a_tdata(da), .output_a_tvalid(va), .output_a_tready(a_rdy),
        .output_b_tdata(db), .output_b_tvalid(vb), .output_b_tready(b_rdy),
        .output_c_tdata(dc), .output_c_tvalid(vc), .output_c_tready(c_rdy),
        .frame_error(fe)
    );

    always @(negedge clk) begin
        if (va && a_rdy) got_a.push_back(da);
        if (vb && b_rdy) got_b.push_back(db);
        if (vc && c_rdy) got_c.push_back(dc);
        if (fe) err_seen++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_a = ($urandom % 4) != 0;
            rnd_b = ($urandom % 4) != 0;
            rnd_c = ($urandom % 4) != 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference framing model: words grouped by tlast; only exact 3-word frames are triples.
    task automatic model(input logic [W-1:0] w, input logic last);
        if (m_drop) begin
            if (last) m_drop = 0;
            return;
        end
        m_cur.push_back(w);
        if (last) begin
            if (m_cur.size() == 3) begin
                exp_a.push_back(m_cur[0]);
                exp_b.push_back(m_cur[1]);
                exp_c.push_back(m_cur[2]);
            end else begin
                exp_err++;
            end
            m_cur.delete();
        end else if (m_cur.size() == 3) begin
            exp_err++;
            m_cur.delete();
            m_drop = 1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic last, input int idle);
        int n = 0;
        repeat (idle) begin @(posedge clk); #1; end
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model(d, last);
    endtask

    task automatic drain();
        int n = 0;
        while (va || vb || vc) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                check("drain_timeout", 32'd1, 32'd0);
                return;
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string phase);
        int ma = 0, mb = 0, mc = 0;
        check({phase, "_err_count"}, err_seen, exp_err);
        check({phase, "_count_a"}, got_a.size(), exp_a.size());
        check({phase, "_count_b"}, got_b.size(), exp_b.size());
        check({phase, "_count_c"}, got_c.size(), exp_c.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) if (got_a[i] !== exp_a[i]) ma++;
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) if (got_b[i] !== exp_b[i]) mb++;
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) if (got_c[i] !== exp_c[i]) mc++;
        check({phase, "_data_a_mismatches"}, ma, 0);
        check({phase, "_data_b_mismatches"}, mb, 0);
        check({phase, "_data_c_mismatches"}, mc, 0);
    endtask

    initial begin
        int unsigned c1, c2, c3;

        // Reset values
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_valid", {va, vb, vc}, 0);
        check("rst_data", {da, db, dc}, 0);
        check("rst_fe", fe, 0);
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1);

        // Basic triple, all ready
        send(16'h0003, 0, 0);
        send(16'h0004, 0, 0);
        send(16'h0005, 1, 0);
        check("basic_valid", {va, vb, vc}, 3'b111);
        check("basic_data", {da, db, dc}, {16'h0003, 16'h0004, 16'h0005});
        @(posedge clk); #1;
        check("basic_retired", {va, vb, vc}, 3'b000);
        check("basic_fe", fe, 0);

        // B stalled for several cycles
        fix_b = 1'b0;
        send(16'h0003, 0, 0);
        send(16'h0004, 0, 0);
        send(16'h0005, 1, 0);
        @(posedge clk); #1;
        check("bstall_valid", {va, vb, vc}, 3'b010);
        repeat (3) begin @(posedge clk); #1; end
        check("bstall_hold_valid", {va, vb, vc}, 3'b010);
        check("bstall_hold_data", db, 16'h0004);
        fix_b = 1'b1;
        @(posedge clk); #1;
        check("bstall_retired", {va, vb, vc}, 3'b000);
        drain();
        check_all("bstall");

        // tlast on the B word
        send(16'h0001, 0, 0);
        send(16'h0002, 1, 0);
        check("short_fe_pulse", fe, 1);
        send(16'h0007, 0, 0);
        check("short_fe_clear", fe, 0);
        send(16'h0008, 0, 0);
        send(16'h0009, 1, 0);
        check("short_data", {da, db, dc}, {16'h0007, 16'h0008, 16'h0009});
        drain();
        check_all("short");

        // C word without tlast, then dropped words
        send(16'h0010, 0, 0);
        send(16'h0020, 0, 0);
        send(16'h0030, 0, 0);
        check("long_fe_pulse", fe, 1);
        send(16'hAAAA, 0, 0);
        send(16'hBBBB, 1, 0);
        check("drop_no_fe", fe, 0);
        check("drop_no_valid", {va, vb, vc}, 3'b000);
        send(16'h0001, 0, 0);
        send(16'h0002, 0, 0);
        send(16'h0003, 1, 0);
        drain();
        check_all("long");

        // Back-to-back throughput
        for (int t = 0; t < 3; t++) begin
            send(W'(3 * t + 16'h100), 0, 0);
            send(W'(3 * t + 16'h101), 0, 0);
            send(W'(3 * t + 16'h102), 1, 0);
            if (t == 0) c1 = acc_cyc;
            else if (t == 1) c2 = acc_cyc;
            else c3 = acc_cyc;
        end
        check("period_1", c2 - c1, EXP_PERIOD);
        check("period_2", c3 - c2, EXP_PERIOD);
        drain();
        check_all("tput");

        // Reset while B is pending
        fix_b = 1'b0;
        send(16'h0055, 0, 0);
        send(16'h0066, 0, 0);
        send(16'h0077, 1, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", {va, vb, vc}, 3'b000);
        check("midrst_ready", in_ready, 0);
        check("midrst_data", {da, db, dc}, 0);
        void'(exp_b.pop_back());
        m_cur.delete();
        m_drop = 0;
        fix_b = 1'b1;
        repeat (2) @(posedge clk);
        #3; rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0011, 0, 0);
        send(16'h0022, 0, 0);
        send(16'h0033, 1, 0);
        check("postrst_data", {da, db, dc}, {16'h0011, 16'h0022, 16'h0033});
        drain();
        check_all("reset");

        // Randomized frames with random output readiness
        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int r, len;
            r = $urandom_range(0, 9);
            if (r < 6) len = 3;
            else if (r == 6) len = 1;
            else if (r == 7) len = 2;
            else len = $urandom_range(4, 6);
            for (int k = 0; k < len; k++)
                send(W'($urandom), (k == len - 1), $urandom_range(0, 1));
        end
        drain();
        rand_rdy = 1'b0;
        check_all("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
